idelay_ctrl_sequencer: RTL and testbench

- Drives the IDELAYCTRL reset/ready handshake on the ROACH infrastructure: generates `idelay_rst` and consumes `idelay_rdy`.
- Holds the delay controller in reset until the system clock DCM reports lock and has settled, then releases reset and waits for ready.
- Retries on timeout and reports calibrated/failed status to the capture logic, e.g. the ADC data-capture IDELAY taps.

---
 rtl/idelay_seq_pkg.sv | 15 +
 rtl/idelay_ctrl_sequencer_if.sv | 23 ++
 rtl/idelay_ctrl_sequencer_sync_2ff.sv | 29 ++
 rtl/idelay_ctrl_sequencer.sv | 119 +++++++++++
 tb/tb_idelay_ctrl_sequencer.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/idelay_seq_pkg.sv
// Shared types and constants for the IDELAYCTRL reset/ready sequencer.
package idelay_seq_pkg;

    localparam int RETRY_W = 4;

    typedef enum logic [2:0] {
        WAIT_LOCK,
        SETTLE,
        WAIT_RDY,
        PULSE,
        READY,
        FAIL
    } seq_state_e;

endpackage

// File: rtl/idelay_ctrl_sequencer_if.sv
// Handshake bundle between the sequencer (master) and the DCM/IDELAYCTRL/capture side (slave).
interface idelay_ctrl_sequencer_if;
    import idelay_seq_pkg::*;

    logic               sys_clk_lock;
    logic               idelay_rdy;
    logic               restart;
    logic               idelay_rst;
    logic               calib_ready;
    logic               calib_fail;
    logic [RETRY_W-1:0] retry_count;

    modport master (
        input  sys_clk_lock, idelay_rdy, restart,
        output idelay_rst, calib_ready, calib_fail, retry_count
    );

    modport slave (
        output sys_clk_lock, idelay_rdy, restart,
        input  idelay_rst, calib_ready, calib_fail, retry_count
    );

endinterface

// File: rtl/idelay_ctrl_sequencer_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, cleared asynchronously.
module sync_2ff (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/idelay_ctrl_sequencer.sv
// Sequences IDELAYCTRL reset release after DCM lock, retries on ready timeout,
// and reports calibrated/failed status. Outputs are decoded from the next state.
module idelay_ctrl_sequencer
    import idelay_seq_pkg::*;
#(
    parameter int RST_CYCLES  = 16,
    parameter int LOCK_SETTLE = 256,
    parameter int RDY_TIMEOUT = 1024,
    parameter int MAX_RETRY   = 7,
    parameter int CNT_W       = 16
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    idelay_ctrl_sequencer_if.master  bus
);

    if (MAX_RETRY > (1 << RETRY_W) - 1) begin : g_chk_max_retry
        $error("MAX_RETRY must fit in the retry_count width");
    end
    if ((RST_CYCLES - 1) >= (1 << CNT_W) || (LOCK_SETTLE - 1) >= (1 << CNT_W) ||
        (RDY_TIMEOUT - 1) >= (1 << CNT_W)) begin : g_chk_cnt_w
        $error("CNT_W too narrow for the configured cycle counts");
    end

    localparam logic [CNT_W-1:0]   SETTLE_LAST  = CNT_W'(LOCK_SETTLE - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(RDY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   PULSE_LAST   = CNT_W'(RST_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRY);

    function automatic logic [RETRY_W-1:0] retry_sat_inc(input logic [RETRY_W-1:0] v);
        return (v >= RETRY_MAX) ? RETRY_MAX : v + 1'b1;
    endfunction

    logic lock_s, rdy_s;

    sync_2ff u_sync_lock (.clk(sys_clk), .clr(sys_rst), .d(bus.sys_clk_lock), .q(lock_s));
    sync_2ff u_sync_rdy  (.clk(sys_clk), .clr(sys_rst), .d(bus.idelay_rdy),   .q(rdy_s));

    seq_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               idelay_rst_q, idelay_rst_d;
    logic               calib_ready_q, calib_ready_d;
    logic               calib_fail_q, calib_fail_d;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q       <= WAIT_LOCK;
            cnt_q         <= '0;
            retry_q       <= '0;
            idelay_rst_q  <= 1'b1;
            calib_ready_q <= 1'b0;
            calib_fail_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_q       <= retry_d;
            idelay_rst_q  <= idelay_rst_d;
            calib_ready_q <= calib_ready_d;
            calib_fail_q  <= calib_fail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        if (bus.restart) begin
            state_d = WAIT_LOCK;
            retry_d = '0;
        end else if (!lock_s && state_q != WAIT_LOCK) begin
            state_d = WAIT_LOCK;
        end else begin
            case (state_q)
                WAIT_LOCK: if (lock_s) state_d = SETTLE;
                SETTLE:    if (cnt_q == SETTLE_LAST) state_d = WAIT_RDY;
                WAIT_RDY: begin
                    // Ready seen on the timeout cycle still counts as success.
                    if (rdy_s) begin
                        state_d = READY;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        if (retry_q < RETRY_MAX) begin
                            retry_d = retry_sat_inc(retry_q);
                            state_d = PULSE;
                        end else begin
                            state_d = FAIL;
                        end
                    end
                end
                PULSE:     if (cnt_q == PULSE_LAST) state_d = WAIT_RDY;
                READY: begin
                    if (!rdy_s) begin
                        state_d = PULSE;
                        retry_d = '0;
                    end
                end
                FAIL:      state_d = FAIL;
                default:   state_d = WAIT_LOCK;
            endcase
        end
        // Timed states restart their count on entry; untimed states park at zero.
        if (state_d != state_q || !(state_d inside {SETTLE, WAIT_RDY, PULSE})) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        idelay_rst_d  = !(state_d == WAIT_RDY || state_d == READY);
        calib_ready_d = (state_d == READY);
        calib_fail_d  = (state_d == FAIL);
    end

    assign bus.idelay_rst  = idelay_rst_q;
    assign bus.calib_ready = calib_ready_q;
    assign bus.calib_fail  = calib_fail_q;
    assign bus.retry_count = retry_q;

endmodule

// File: tb/tb_idelay_ctrl_sequencer.sv
// Directed bench for idelay_ctrl_sequencer with short timing parameters.
module tb_idelay_ctrl_sequencer;
    import idelay_seq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    idelay_ctrl_sequencer_if u_if ();

    idelay_ctrl_sequencer #(
        .RST_CYCLES (4),
        .LOCK_SETTLE(8),
        .RDY_TIMEOUT(16),
        .MAX_RETRY  (2),
        .CNT_W      (16)
    ) u_dut (
        .sys_clk(clk),
        .sys_rst(rst),
        .bus    (u_if.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    initial begin
        u_if.sys_clk_lock = 1'b0;
        u_if.idelay_rdy   = 1'b0;
        u_if.restart      = 1'b0;
        tick(2);
        chk("rst_idelay_rst",  u_if.idelay_rst, 1);
        chk("rst_calib_ready", u_if.calib_ready, 0);
        chk("rst_calib_fail",  u_if.calib_fail, 0);
        chk("rst_retry",       u_if.retry_count, 0);

        // Nominal bring-up: lock rises now, idelay_rst falls at edge 11.
        rst = 1'b0;
        u_if.sys_clk_lock = 1'b1;
        tick(10);
        chk("s1_rst_hold_e10", u_if.idelay_rst, 1);
        tick(1);
        chk("s1_rst_fall_e11", u_if.idelay_rst, 0);
        chk("s1_retry",        u_if.retry_count, 0);
        tick(5);
        u_if.idelay_rdy = 1'b1;
        tick(2);
        chk("s1_ready_e2", u_if.calib_ready, 0);
        tick(1);
        chk("s1_ready_e3", u_if.calib_ready, 1);
        chk("s1_rst_low",  u_if.idelay_rst, 0);

        // Ready never arrives: two retry pulses then FAIL at edge 67.
        u_if.idelay_rdy = 1'b0;
        pulse_reset();
        tick(11);
        chk("s2_rst_fall", u_if.idelay_rst, 0);
        tick(16);
        chk("s2_pulse1_rst",   u_if.idelay_rst, 1);
        chk("s2_pulse1_retry", u_if.retry_count, 1);
        tick(4);
        chk("s2_pulse1_end", u_if.idelay_rst, 0);
        tick(16);
        chk("s2_pulse2_rst",   u_if.idelay_rst, 1);
        chk("s2_pulse2_retry", u_if.retry_count, 2);
        tick(4);
        chk("s2_pulse2_end", u_if.idelay_rst, 0);
        tick(15);
        chk("s2_fail_early", u_if.calib_fail, 0);
        tick(1);
        chk("s2_fail",       u_if.calib_fail, 1);
        chk("s2_fail_retry", u_if.retry_count, 2);
        chk("s2_fail_rst",   u_if.idelay_rst, 1);
        chk("s2_fail_ready", u_if.calib_ready, 0);
        tick(3);
        chk("s2_fail_hold", u_if.calib_fail, 1);

        // Restart out of FAIL; lock is still up so SETTLE follows immediately.
        u_if.restart = 1'b1;
        tick(1);
        u_if.restart = 1'b0;
        chk("s3_fail_clr",  u_if.calib_fail, 0);
        chk("s3_retry_clr", u_if.retry_count, 0);
        chk("s3_rst_high",  u_if.idelay_rst, 1);
        tick(8);
        chk("s3_settle_hold", u_if.idelay_rst, 1);
        tick(1);
        chk("s3_rst_fall", u_if.idelay_rst, 0);
        u_if.idelay_rdy = 1'b1;
        tick(2);
        chk("s3_ready_e2", u_if.calib_ready, 0);
        tick(1);
        chk("s3_ready_e3", u_if.calib_ready, 1);

        // Lock loss in READY, then a full settle on its return.
        u_if.sys_clk_lock = 1'b0;
        tick(2);
        chk("s4_ready_e2", u_if.calib_ready, 1);
        tick(1);
        chk("s4_ready_drop", u_if.calib_ready, 0);
        chk("s4_rst_high",   u_if.idelay_rst, 1);
        u_if.sys_clk_lock = 1'b1;
        tick(10);
        chk("s4_settle_hold", u_if.idelay_rst, 1);
        tick(1);
        chk("s4_rst_fall", u_if.idelay_rst, 0);
        tick(1);
        chk("s4_ready_back", u_if.calib_ready, 1);
        chk("s4_retry",      u_if.retry_count, 0);

        // Two-cycle ready dropout in READY: one 4-cycle reset pulse.
        u_if.idelay_rdy = 1'b0;
        tick(2);
        u_if.idelay_rdy = 1'b1;
        chk("s5_ready_hold", u_if.calib_ready, 1);
        tick(1);
        chk("s5_ready_drop", u_if.calib_ready, 0);
        chk("s5_pulse_rst",  u_if.idelay_rst, 1);
        chk("s5_retry",      u_if.retry_count, 0);
        tick(3);
        chk("s5_pulse_last", u_if.idelay_rst, 1);
        tick(1);
        chk("s5_pulse_end", u_if.idelay_rst, 0);
        tick(1);
        chk("s5_ready_back", u_if.calib_ready, 1);

        // Asynchronous reset mid-cycle during the second WAIT_RDY window.
        u_if.idelay_rdy = 1'b0;
        pulse_reset();
        tick(35);
        chk("s6_pre_retry", u_if.retry_count, 1);
        chk("s6_pre_rst",   u_if.idelay_rst, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("s6_async_rst",   u_if.idelay_rst, 1);
        chk("s6_async_ready", u_if.calib_ready, 0);
        chk("s6_async_fail",  u_if.calib_fail, 0);
        chk("s6_async_retry", u_if.retry_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
